// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per load/store, formats
// load data and stalls the front of the pipe. Optional `MISALIGN_CHK_EN` traps misaligned accesses.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] data_q;
  logic        bus_err_q;
  logic        misalign_q;

  logic        is_load, is_store, mem_op, misaligned, timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  assign is_load     = valid_in && (opcode_in == OP_LOAD);
  assign is_store    = valid_in && (opcode_in == OP_STORE);
  assign mem_op      = is_load || is_store;
  // The counter value seen here is the number of ack-less BUSY cycles already spent.
  assign timeout_hit = (32'(cnt) + 32'd1) >= TIMEOUT_CYCLES;

`ifdef MISALIGN_CHK_EN
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      case (funct3_in)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = addr_in[0];
        default:        misaligned = |addr_in[1:0];
      endcase
    end else if (is_store) begin
      case (funct3_in)
        3'b000:  misaligned = 1'b0;
        3'b001:  misaligned = addr_in[0];
        default: misaligned = |addr_in[1:0];
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data_in;
    if (is_store) begin
      case (funct3_in)
        3'b000: begin
          be_next    = 4'b0001 << addr_in[1:0];
          wdata_next = {4{store_data_in[7:0]}};
        end
        3'b001: begin
          be_next    = 4'b0011 << {addr_in[1], 1'b0};
          wdata_next = {2{store_data_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (mem_op) state_next = misaligned ? DONE : BUSY;
      BUSY:    if (dmem_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      data_q     <= 32'd0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (mem_op) begin
            cnt        <= 8'd0;
            data_q     <= 32'd0;
            bus_err_q  <= 1'b0;
            misalign_q <= misaligned;
            if (!misaligned) begin
              funct3_q   <= funct3_in;
              lane_q     <= addr_in[1:0];
              dmem_we    <= is_store;
              dmem_addr  <= {addr_in[31:2], 2'b00};
              dmem_wdata <= wdata_next;
              dmem_be    <= be_next;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            // Ack beats a simultaneous timeout; stores leave data_q at zero.
            if (!dmem_we) data_q <= fmt_load(funct3_q, lane_q, dmem_rdata);
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            data_q    <= 32'd0;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req = (state == BUSY);

  always_comb begin
    stall        = 1'b0;
    valid_out    = 1'b0;
    data_out     = 32'd0;
    bus_err      = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      IDLE: begin
        stall     = mem_op;
        valid_out = valid_in && !mem_op;
      end
      BUSY: stall = 1'b1;
      DONE: begin
        valid_out    = 1'b1;
        data_out     = data_q;
        bus_err      = bus_err_q;
        misalign_err = misalign_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (TIMEOUT_CYCLES=4): expected results are queued
// at issue and compared whenever valid_out is seen.
module tb_mem_stage_lsu;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, store_data_in, dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] data_out;
  logic        valid_out, stall, bus_err, misalign_err;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .data_out(data_out), .valid_out(valid_out), .stall(stall),
    .bus_err(bus_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        berr;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && valid_out) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", data_out, e.data);
        check("sb_bus_err", 32'(bus_err), 32'(e.berr));
        check("sb_misalign", 32'(misalign_err), 32'(e.mis));
      end
    end
  end

  // Drives one access, answers with ack in BUSY cycle ack_at (-1: never) and
  // snapshots the request seen in the first BUSY cycle.
  task automatic mem_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                        input int ack_at, input logic [31:0] exp_data, input logic exp_berr,
                        input logic exp_mis, output int busy, output logic [31:0] s_addr,
                        output logic [3:0] s_be, output logic [31:0] s_wdata, output logic s_we);
    int unstable;
    bit done;
    busy = 0; unstable = 0; done = 0;
    s_addr = '0; s_be = '0; s_wdata = '0; s_we = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b1; opcode_in = op; funct3_in = f3; addr_in = addr;
    store_data_in = sd; dmem_ack = 1'b0; dmem_rdata = rdata;
    sb.push_back('{data: exp_data, berr: exp_berr, mis: exp_mis});
    @(negedge clk);
    check({tag, "_issue_stall"}, 32'(stall), 32'd1);
    check({tag, "_issue_req"}, 32'(dmem_req), 32'd0);
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge clk); #1;
      dmem_ack = (n == ack_at);
      @(negedge clk);
      if (valid_out) begin
        done = 1;
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        check({tag, "_done_req"}, 32'(dmem_req), 32'd0);
      end else begin
        check({tag, "_busy_stall"}, 32'(stall), 32'd1);
        check({tag, "_busy_req"}, 32'(dmem_req), 32'd1);
        if (busy == 0) begin
          s_addr = dmem_addr; s_be = dmem_be; s_wdata = dmem_wdata; s_we = dmem_we;
        end else if (dmem_addr !== s_addr || dmem_be !== s_be ||
                     dmem_wdata !== s_wdata || dmem_we !== s_we) begin
          unstable++;
        end
        busy++;
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    check({tag, "_req_stable"}, 32'(unstable), 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check({tag, "_valid_one_cycle"}, 32'(valid_out), 32'd0);
  endtask

  int          busy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; opcode_in = '0; funct3_in = '0; addr_in = '0;
    store_data_in = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_errs", 32'({bus_err, misalign_err}), 32'd0);
    reset = 1'b1;

    // LB sign-extended, ack in first BUSY cycle: stall for 2 cycles total.
    mem_op("lb", OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0,
           32'hFFFF_FF80, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("lb_busy_cycles", 32'(busy), 32'd1);
    check("lb_be", 32'(s_be), 32'hF);
    check("lb_we", 32'(s_we), 32'd0);
    check("lb_addr", s_addr, 32'h100);

    mem_op("sh", OP_STORE, 3'b001, 32'h202, 32'h0000_ABCD, 32'hFFFF_FFFF, 1,
           32'h0, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("sh_busy_cycles", 32'(busy), 32'd2);
    check("sh_be", 32'(s_be), 32'b1100);
    check("sh_wdata", s_wdata, 32'hABCD_ABCD);
    check("sh_addr", s_addr, 32'h200);
    check("sh_we", 32'(s_we), 32'd1);

    mem_op("sb", OP_STORE, 3'b000, 32'h001, 32'h1234_5678, 32'h0, 0,
           32'h0, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("sb_be", 32'(s_be), 32'b0010);
    check("sb_wdata", s_wdata, 32'h7878_7878);

    mem_op("sw", OP_STORE, 3'b010, 32'h010, 32'hDEAD_BEEF, 32'h0, 2,
           32'h0, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("sw_be", 32'(s_be), 32'hF);
    check("sw_wdata", s_wdata, 32'hDEAD_BEEF);
    check("sw_addr", s_addr, 32'h010);

    mem_op("lbu", OP_LOAD, 3'b100, 32'h102, 32'h0, 32'h11AB_2233, 0,
           32'h0000_00AB, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    mem_op("lh", OP_LOAD, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1,
           32'hFFFF_8001, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    mem_op("lhu", OP_LOAD, 3'b101, 32'h100, 32'h0, 32'h8001_F234, 0,
           32'h0000_F234, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    mem_op("lw", OP_LOAD, 3'b010, 32'h104, 32'h0, 32'hCAFE_BABE, 0,
           32'hCAFE_BABE, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);

    // Non-memory op passes straight through with no stall.
    @(posedge clk); #1;
    valid_in = 1'b1; opcode_in = OP_ALU; funct3_in = 3'b000; addr_in = 32'h55;
    sb.push_back('{data: 32'h0, berr: 1'b0, mis: 1'b0});
    @(negedge clk);
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_valid", 32'(valid_out), 32'd1);
    check("alu_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;

    // Timeout with no ack, then a late ack must be ignored.
    mem_op("tmo", OP_LOAD, 3'b010, 32'h500, 32'h0, 32'h1234_5678, -1,
           32'h0, 1'b1, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("tmo_busy_cycles", 32'(busy), 32'd4);
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(negedge clk);
    check("tmo_late_ack_valid", 32'(valid_out), 32'd0);
    check("tmo_late_ack_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    // Ack arriving on the cycle the timeout is reached wins.
    mem_op("ack_at_tmo", OP_LOAD, 3'b010, 32'h504, 32'h0, 32'h0BAD_F00D, 3,
           32'h0BAD_F00D, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("ack_at_tmo_busy_cycles", 32'(busy), 32'd4);

    // Misaligned word load.
`ifdef MISALIGN_CHK_EN
    mem_op("lw_mis", OP_LOAD, 3'b010, 32'h301, 32'h0, 32'h7777_7777, 0,
           32'h0, 1'b0, 1'b1, busy, s_addr, s_be, s_wdata, s_we);
    check("lw_mis_busy_cycles", 32'(busy), 32'd0);
`else
    mem_op("lw_mis", OP_LOAD, 3'b010, 32'h301, 32'h0, 32'h7777_7777, 0,
           32'h7777_7777, 1'b0, 1'b0, busy, s_addr, s_be, s_wdata, s_we);
    check("lw_mis_busy_cycles", 32'(busy), 32'd1);
    check("lw_mis_addr", s_addr, 32'h300);
`endif

    // Reset in the 2nd BUSY cycle abandons the access; a following ack is ignored.
    @(posedge clk); #1;
    valid_in = 1'b1; opcode_in = OP_LOAD; funct3_in = 3'b010; addr_in = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstb_req_before", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b0; valid_in = 1'b0;
    #1;
    check("rstb_req", 32'(dmem_req), 32'd0);
    check("rstb_stall", 32'(stall), 32'd0);
    check("rstb_addr", dmem_addr, 32'd0);
    check("rstb_valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(negedge clk);
    check("rstb_late_ack_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rstb_after_valid", 32'(valid_out), 32'd0);
    check("rstb_after_req", 32'(dmem_req), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, which sets the number of BUSY cycles without dmem_ack before a bus error.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 valid_in  input  1  the EX/MEM instruction is valid.
REQ-005 opcode_in  input  7  instruction opcode: load 0000011, store 0100011.
REQ-006 funct3_in  input  3  access size and signedness.
REQ-007 addr_in  input  32  effective address (ALU result).
REQ-008 store_data_in  input  32  rs2 value to store.
REQ-009 dmem_rdata  input  32  memory read word.
REQ-010 dmem_ack  input  1  one-cycle completion strobe from memory.
REQ-011 dmem_req  output  1  memory request, held until ack or timeout.
REQ-012 dmem_we  output  1  write enable; 1 for stores.
REQ-013 dmem_addr  output  32  word-aligned address {addr_in[31:2],2'b00}.
REQ-014 dmem_wdata  output  32  lane-replicated store data.
REQ-015 dmem_be  output  4  byte enables.
REQ-016 data_out  output  32  formatted load result, sent to the MEM/WB register.
REQ-017 valid_out  output  1  data_out and the status flags are valid this cycle.
REQ-018 stall  output  1  freezes IF through EX/MEM while high.
REQ-019 bus_err  output  1  the access timed out.
REQ-020 misalign_err  output  1  misaligned access; see Configuration.

Function
REQ-021 A memory op SHALL be valid_in=1 with a load or store opcode; every other opcode is a non-memory op.
- Non-memory op in IDLE: stall=0, valid_out=valid_in, data_out=0, combinationally.
REQ-022 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE→BUSY on a memory op.
- BUSY→DONE on dmem_ack, or when the timeout counter reaches TIMEOUT_CYCLES.
- DONE→IDLE unconditionally.
REQ-023 stall SHALL be 1 in IDLE while a memory op is presented, and 1 throughout BUSY; stall SHALL be 0 in DONE.
REQ-024 dmem_req SHALL be 1 only in BUSY.
- dmem_addr, dmem_we, dmem_wdata and dmem_be stay stable for the whole request.
REQ-025 Store byte enables and data:
- SB (000): dmem_be=0001<<addr[1:0]; wdata = byte replicated ×4.
- SH (001): dmem_be=0011<<{addr[1],1'b0}; wdata = halfword replicated ×2.
- Other funct3 values (SW): dmem_be=1111; wdata = store_data_in.
REQ-026 Loads SHALL drive dmem_be=1111.
- On ack, the addressed lane is captured into the data_out register.
- LB and LH sign-extend; LBU (100) and LHU (101) zero-extend; other funct3 values return the full word (LW).
REQ-027 In DONE: valid_out=1 and data_out holds the captured value (0 for stores).
- The minimum load-to-use latency is 2 cycles after IDLE issue, when ack arrives in the first BUSY cycle.
REQ-028 The timeout counter (8 bits, saturating) SHALL clear on BUSY entry and increment each BUSY cycle without ack.
- On timeout: dmem_req drops, DONE with bus_err=1 and data_out=0.
REQ-029 If dmem_ack arrives in the same cycle the timeout is reached, the ack SHALL win, with bus_err=0.
REQ-030 dmem_ack received in IDLE or DONE SHALL be ignored.
REQ-031 bus_err and misalign_err SHALL be valid only while valid_out=1; they are 0 otherwise.

Reset
REQ-032 An asynchronous reset assertion SHALL force, immediately:
- state=IDLE and counter=0;
- dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0;
- data_out=0, valid_out=0, bus_err=0, misalign_err=0.
REQ-033 Reset during BUSY SHALL abandon the access; a late ack after reset is ignored.

Configuration
REQ-034 With MISALIGN_CHK_EN defined, an access SHALL be misaligned if it is halfword with addr[0]=1, or word with addr[1:0]≠0.
- A misaligned access skips BUSY: IDLE→DONE with no dmem_req.
- In DONE: misalign_err=1, data_out=0, stall=1 for exactly one cycle (the IDLE cycle).
REQ-035 Without MISALIGN_CHK_EN, misalign_err SHALL be tied to 0.
- Address low bits not used by the access size are ignored, per REQ-025 and REQ-026.

Verification
REQ-036 LB at addr 0x103, rdata 0x80FF_FF00, ack in the 1st BUSY cycle → data_out=0xFFFF_FF80, valid_out high exactly 1 cycle, stall high 2 cycles.
REQ-037 SH at addr 0x202, store_data 0x0000_ABCD → dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_addr=0x200, dmem_we=1.
REQ-038 LW with no ack and TIMEOUT_CYCLES=4 → dmem_req high 4 cycles, then bus_err=1, data_out=0; a late ack is ignored.
REQ-039 Reset asserted in the 2nd BUSY cycle of a load → dmem_req=0 and state IDLE immediately; an ack one cycle later causes no valid_out.
REQ-040 LW at addr 0x301:
- With MISALIGN_CHK_EN: misalign_err=1 next cycle, no dmem_req.
- Without it: dmem_addr=0x300, normal load.
